regex_cmd_controller: RTL
=========================

// Module: regex_cmd_controller
// PURPOSE
//  Command sequencer between the AXI-lite register file and the regex coprocessor.
//  - Decodes software command words (NOP/WRITE/READ/START/RESET/READ_ELAPSED_CLOCK/RESTART).
//  - Drives the coprocessor memory port and the start/reset controls.
//  - Produces the status word read back by software: IDLE=0, RUNNING=1, ACCEPTED=2, REJECTED=3, ERROR=4.
// PARAMETERS
//  REG_WIDTH      40     width of data_i/data_o; data_i = {addr[ADDR_WIDTH-1:0], wdata[DATA_WIDTH-1:0]}
//  ADDR_WIDTH     8      coprocessor memory address width
//  DATA_WIDTH     32     coprocessor memory data width; ADDR_WIDTH+DATA_WIDTH == REG_WIDTH
//  CNT_WIDTH      32     elapsed-clock counter width, <= REG_WIDTH
//  TIMEOUT_CYCLES 2**20  run limit, used only with REGEX_CMD_TIMEOUT_EN
// PORTS
//  clk           in   1           system clock
//  rst_n         in   1           asynchronous active-low reset
//  cmd_i         in   32          command opcode
//  cmd_valid_i   in   1           1-cycle pulse: cmd_i/data_i written by software
//  data_i        in   REG_WIDTH   command argument {addr, wdata}
//  data_o        out  REG_WIDTH   read result / elapsed count
//  status_o      out  32          status code
//  mem_addr_o    out  ADDR_WIDTH  memory address
//  mem_wdata_o   out  DATA_WIDTH  memory write data
//  mem_we_o      out  1           memory write strobe, 1 cycle
//  mem_re_o      out  1           memory read request, 1 cycle
//  mem_rdata_i   in   DATA_WIDTH  memory read data, valid with mem_rvalid_i
//  mem_rvalid_i  in   1           read data valid
//  cp_start_o    out  1           coprocessor start pulse, 1 cycle
//  cp_restart_o  out  1           qualifies cp_start_o as resume-after-match
//  cp_rst_o      out  1           coprocessor synchronous reset pulse, 1 cycle
//  cp_done_i     in   1           coprocessor finished; result on cp_accept_i
//  cp_accept_i   in   1           1 = accepted, 0 = rejected
// BEHAVIOUR
//  Reset:
//  - All outputs 0; status_o = IDLE; counter = 0; FSM = IDLE.
//  FSM states: IDLE, READ_WAIT, RUN, DONE. Commands are decoded only when cmd_valid_i=1.
//  Commands accepted in IDLE/DONE (all take effect at the sampling edge):
//  - WRITE: mem_addr_o/mem_wdata_o loaded from data_i; mem_we_o=1 for one cycle; status unchanged.
//  - READ: mem_addr_o loaded; mem_re_o=1 for one cycle; -> READ_WAIT.
//    - First edge with mem_rvalid_i=1: data_o = {mem_addr_o, mem_rdata_i}; return to the previous state.
//  - START: cp_start_o=1 (cp_restart_o=0) for one cycle; counter cleared; status=RUNNING; -> RUN.
//  - RESTART in DONE with status ACCEPTED/REJECTED: cp_start_o=1 and cp_restart_o=1 for one cycle.
//    Counter keeps its value; status=RUNNING; -> RUN.
//  - RESTART in IDLE, or in DONE with status ERROR: status=ERROR; state unchanged.
//  - READ_ELAPSED_CLOCK: data_o = zero-extended counter, next edge.
//  - NOP: no effect.
//  - Unknown opcode: status=ERROR; state unchanged.
//  Commands in RUN or READ_WAIT:
//  - RESET: honoured.
//  - READ_ELAPSED_CLOCK: honoured; in RUN it returns the live count.
//  - Any other opcode: ignored, no status change.
//  RESET (any state): cp_rst_o=1 for one cycle; status=IDLE; counter=0; data_o=0; -> IDLE.
//  - Priority over a same-cycle cp_done_i or mem_rvalid_i.
//  RUN:
//  - Counter +1 on every edge in RUN, including the edge that samples cp_done_i.
//  - Counter saturates at 2**CNT_WIDTH-1; no wrap.
//  - cp_done_i=1: status = cp_accept_i ? ACCEPTED : REJECTED; -> DONE.
//  - START with cp_done_i asserted N edges later gives elapsed = N.
//  - cp_done_i outside RUN is ignored.
// CONFIGURATION
//  REGEX_CMD_TIMEOUT_EN defined:
//  - On the edge where counter reaches TIMEOUT_CYCLES in RUN: status=ERROR; cp_rst_o=1 for one cycle; -> DONE.
//  - A same-edge cp_done_i wins over the timeout.
//  REGEX_CMD_TIMEOUT_EN undefined:
//  - No timeout logic; RUN lasts until cp_done_i or RESET.
// TESTING
//  1. WRITE data_i=40'h05_DEADBEEF -> next cycle mem_we_o=1, mem_addr_o=8'h05, mem_wdata_o=32'hDEADBEEF; status stays 0.
//  2. READ addr 8'h05; mem_rvalid_i 3 cycles later with 32'hCAFEF00D -> data_o=40'h05_CAFEF00D; mem_re_o pulsed once.
//  3. START; cp_done_i with cp_accept_i=1 ten edges later -> status 1 then 2.
//     READ_ELAPSED_CLOCK -> data_o=10.
//     RESTART; done 4 edges later with cp_accept_i=0 -> status 3, elapsed=14.
//  4. START; RESET 5 cycles later in the same cycle as cp_done_i -> cp_rst_o pulse; status 0; elapsed 0.
//  5. Opcode 'h7 in IDLE -> status 4. RESTART after reset -> status 4. WRITE during RUN -> mem_we_o stays 0.
//  6. REGEX_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, START with no done -> status 4 at edge 16; one cp_rst_o pulse.
//     Without the macro: still status 1 at edge 100.

Source files
------------

// File: rtl/regex_cmd_controller.sv
// Command sequencer between the AXI-lite register file and the regex coprocessor.
// Optional run timeout enabled by defining REGEX_CMD_TIMEOUT_EN.
module regex_cmd_controller #(
  parameter int unsigned REG_WIDTH      = 40,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           cmd_i,
  input  logic                  cmd_valid_i,
  input  logic [REG_WIDTH-1:0]  data_i,
  output logic [REG_WIDTH-1:0]  data_o,
  output logic [31:0]           status_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  cp_start_o,
  output logic                  cp_restart_o,
  output logic                  cp_rst_o,
  input  logic                  cp_done_i,
  input  logic                  cp_accept_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_RUN, S_DONE} state_t;

  localparam logic [31:0] OP_NOP          = 32'd0;
  localparam logic [31:0] OP_WRITE        = 32'd1;
  localparam logic [31:0] OP_READ         = 32'd2;
  localparam logic [31:0] OP_START        = 32'd3;
  localparam logic [31:0] OP_RESET        = 32'd4;
  localparam logic [31:0] OP_READ_ELAPSED = 32'd5;
  localparam logic [31:0] OP_RESTART      = 32'd6;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUNNING  = 3'd1;
  localparam logic [2:0] ST_ACCEPTED = 3'd2;
  localparam logic [2:0] ST_REJECTED = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

`ifdef REGEX_CMD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t                r_state, w_state_nxt, r_ret_state, w_ret_nxt;
  logic [2:0]            r_status, w_status_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [REG_WIDTH-1:0]  r_data, w_data_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_we, w_we_nxt, r_re, w_re_nxt;
  logic                  r_start, w_start_nxt, r_restart, w_restart_nxt, r_cp_rst, w_cp_rst_nxt;
  logic                  w_cmd_reset, w_cmd_elapsed, w_timeout_hit;

  assign w_cmd_reset   = cmd_valid_i && (cmd_i == OP_RESET);
  assign w_cmd_elapsed = cmd_valid_i && (cmd_i == OP_READ_ELAPSED);
  // Saturating increment; the timeout compares the post-increment value.
  assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
  assign w_timeout_hit = TIMEOUT_EN && (64'(w_cnt_inc) == 64'(TIMEOUT_CYCLES));

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret_state;
    w_status_nxt  = r_status;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_we_nxt      = 1'b0;
    w_re_nxt      = 1'b0;
    w_start_nxt   = 1'b0;
    w_restart_nxt = 1'b0;
    w_cp_rst_nxt  = 1'b0;

    if (w_cmd_reset) begin
      w_cp_rst_nxt = 1'b1;
      w_status_nxt = ST_IDLE;
      w_cnt_nxt    = '0;
      w_data_nxt   = '0;
      w_state_nxt  = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (cmd_valid_i) begin
            case (cmd_i)
              OP_NOP: begin end
              OP_WRITE: begin
                w_addr_nxt  = data_i[REG_WIDTH-1 -: ADDR_WIDTH];
                w_wdata_nxt = data_i[DATA_WIDTH-1:0];
                w_we_nxt    = 1'b1;
              end
              OP_READ: begin
                w_addr_nxt  = data_i[REG_WIDTH-1 -: ADDR_WIDTH];
                w_re_nxt    = 1'b1;
                w_ret_nxt   = r_state;
                w_state_nxt = S_READ_WAIT;
              end
              OP_START: begin
                w_start_nxt  = 1'b1;
                w_cnt_nxt    = '0;
                w_status_nxt = ST_RUNNING;
                w_state_nxt  = S_RUN;
              end
              OP_RESTART: begin
                if (r_state == S_DONE &&
                    (r_status == ST_ACCEPTED || r_status == ST_REJECTED)) begin
                  w_start_nxt   = 1'b1;
                  w_restart_nxt = 1'b1;
                  w_status_nxt  = ST_RUNNING;
                  w_state_nxt   = S_RUN;
                end else begin
                  w_status_nxt  = ST_ERROR;
                end
              end
              OP_READ_ELAPSED: w_data_nxt = REG_WIDTH'(r_cnt);
              default:         w_status_nxt = ST_ERROR;
            endcase
          end
        end
        S_READ_WAIT: begin
          if (w_cmd_elapsed) w_data_nxt = REG_WIDTH'(r_cnt);
          if (mem_rvalid_i) begin
            w_data_nxt  = {r_addr, mem_rdata_i};
            w_state_nxt = r_ret_state;
          end
        end
        S_RUN: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cmd_elapsed) w_data_nxt = REG_WIDTH'(r_cnt);
          if (cp_done_i) begin
            w_status_nxt = cp_accept_i ? ST_ACCEPTED : ST_REJECTED;
            w_state_nxt  = S_DONE;
          end else if (w_timeout_hit) begin
            w_status_nxt = ST_ERROR;
            w_cp_rst_nxt = 1'b1;
            w_state_nxt  = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ret_state <= S_IDLE;
      r_status    <= ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_start     <= 1'b0;
      r_restart   <= 1'b0;
      r_cp_rst    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_status    <= w_status_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data      <= w_data_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_re        <= w_re_nxt;
      r_start     <= w_start_nxt;
      r_restart   <= w_restart_nxt;
      r_cp_rst    <= w_cp_rst_nxt;
    end
  end

  assign data_o       = r_data;
  assign status_o     = 32'(r_status);
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_we_o     = r_we;
  assign mem_re_o     = r_re;
  assign cp_start_o   = r_start;
  assign cp_restart_o = r_restart;
  assign cp_rst_o     = r_cp_rst;

endmodule
